// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master controller.
package spi_pkg;

    localparam int unsigned SPI_DATA_W  = 8;
    localparam int unsigned SPI_CLK_DIV = 4;
    localparam int unsigned SPI_CS_GAP  = 2;

    // Transfer sequencing states of the master FSM.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } spi_mst_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Phase-tick generator: pulses tick_o on the last CLK cycle of every CLK_DIV-cycle phase.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] div_cnt_q;

    assign tick_o = (div_cnt_q == CntW'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1, wrapping at each phase boundary; held at 0 while cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-transfer SPI master (mode 0, MSB first) with a valid/ready byte interface.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV,
    parameter int unsigned CS_GAP  = SPI_CS_GAP
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCK,
    output logic              CS,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned BitW = $clog2(DATA_W);
    localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    spi_mst_state_t    state_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              last_bit_q;
    logic              tx_ready_q;
    logic              rx_valid_q;
    logic              busy_q;
    logic              sck_q;
    logic              cs_q;
    logic              mosi_q;
    logic              tick;
    logic              is_last_bit;

    // The divider restarts from 0 while idle so SETUP always lasts a full phase.
    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (state_q == IDLE),
        .tick_o  (tick)
    );

    assign is_last_bit = (bit_cnt_q == BitW'(DATA_W - 1));

    // Transfer FSM with all interface outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (tx_ready_q && tx_valid) begin
                        tx_shift_q <= tx_data;
                        rx_shift_q <= '0;
                        bit_cnt_q  <= '0;
                        last_bit_q <= 1'b0;
                        mosi_q     <= tx_data[DATA_W-1];
                        cs_q       <= 1'b0;
                        sck_q      <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        state_q <= SCK_HI;
                    end
                end
                SCK_HI: begin
                    if (tick) begin
                        sck_q      <= 1'b0;
                        rx_shift_q <= {rx_shift_q[DATA_W-2:0], MISO};
                        tx_shift_q <= tx_shift_q << 1;
                        mosi_q     <= is_last_bit ? 1'b0 : tx_shift_q[DATA_W-2];
                        // Flag the final bit here so the counter may wrap freely.
                        last_bit_q <= is_last_bit;
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        state_q    <= SCK_LO;
                    end
                end
                SCK_LO: begin
                    if (tick) begin
                        if (last_bit_q) begin
                            state_q <= HOLD;
                        end else begin
                            sck_q   <= 1'b1;
                            state_q <= SCK_HI;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q       <= 1'b1;
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        gap_cnt_q  <= '0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GapW'(CS_GAP - 1)) begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign SCK      = sck_q;
    assign CS       = cs_q;
    assign MOSI     = mosi_q;

endmodule
